// File: rtl/color_ctrl_pkg.sv
// Shared definitions for the colour-select controller.
//
// Contents:
//   COLOR_W_DEF    - default width of the colour index (3 bits: r,g,b)
//   COLOR_INIT_DEF - default reset / chord-load colour (001 = blue)
//   rep_state_e    - per-button auto-repeat state (IDLE, DELAY, REPEAT)
package color_ctrl_pkg;

    localparam int COLOR_W_DEF    = 3;
    localparam int COLOR_INIT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

endpackage

// File: rtl/btn_debounce_repeat.sv
// One push button: 2-flop synchroniser, debounce counter and auto-repeat FSM.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   btn_raw    - raw asynchronous button level, active-high
//   force_idle - holds the repeat FSM in IDLE and suppresses steps (chord held)
//   level      - debounced stable button level
//   press      - one-cycle pulse on a stable 0->1 transition
//   step       - one-cycle step request (press or auto-repeat)
module btn_debounce_repeat
    import color_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic force_idle,
    output logic level,
    output logic press,
    output logic step
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    rep_state_e       state_q, state_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_step;

    // The counter holds DEBOUNCE_CYCLES once that many consecutive synchronised
    // samples disagreed; the stable level flips on the following edge.
    always_comb begin
        level_d  = level_q;
        press_d  = 1'b0;
        db_cnt_d = db_cnt_q;
        if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            press_d  = ~level_q;
            db_cnt_d = '0;
        end else if (sync2_q != level_q) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end else begin
            db_cnt_d = '0;
        end
    end

    // Release or a held chord always parks the FSM; with REPEAT_DELAY=0 it
    // never leaves IDLE so only the press event produces a step.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rep_step  = 1'b0;
        if (!level_q || force_idle || (REPEAT_DELAY == 0)) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        state_d   = DELAY;
                        rep_cnt_d = '0;
                    end
                end
                DELAY: begin
                    if (rep_cnt_q == DELAY_LAST) begin
                        rep_step  = 1'b1;
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                REPEAT: begin
                    if (rep_cnt_q == PERIOD_LAST) begin
                        rep_step  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign step  = (press_q | rep_step) & ~force_idle;

endmodule

// File: rtl/color_select_ctrl.sv
// Board-level user-input controller: two debounced buttons step a colour
// index up/down (with auto-repeat), both together reload the initial colour,
// and the DIP switches are synchronised into square enables.
//
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   push_buttons  - raw buttons, [0]=up, [1]=down, active-high
//   dip_switch    - raw DIP switches
//   color         - current colour index (registered)
//   squares       - synchronised square enables (registered)
//   color_changed - one-cycle pulse when color takes a new value
module color_select_ctrl
    import color_ctrl_pkg::*;
#(
    parameter int COLOR_W         = COLOR_W_DEF,
    parameter int COLOR_INIT      = COLOR_INIT_DEF,
    parameter int NUM_SQUARES     = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int WRAP            = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             push_buttons,
    input  logic [NUM_SQUARES-1:0] dip_switch,
    output logic [COLOR_W-1:0]     color,
    output logic [NUM_SQUARES-1:0] squares,
    output logic                   color_changed
);

    localparam logic [COLOR_W-1:0] COLOR_MAX = '1;
    localparam logic [COLOR_W-1:0] INIT_VAL  = COLOR_W'(COLOR_INIT);

    logic [1:0]             level, press, step;
    logic                   both_held, chord;
    logic [COLOR_W-1:0]     color_q, color_d;
    logic                   color_changed_q, color_changed_d;
    logic [NUM_SQUARES-1:0] dip_s1_q, squares_q;

    for (genvar b = 0; b < 2; b++) begin : g_btn
        btn_debounce_repeat #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_btn (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (push_buttons[b]),
            .force_idle(both_held),
            .level     (level[b]),
            .press     (press[b]),
            .step      (step[b])
        );
    end

    // Both stable levels high can only arise through a press while the other
    // button was held, so holding the FSMs idle on both_held covers the chord.
    assign both_held = level[0] & level[1];
    assign chord     = both_held & (press[0] | press[1]);

    always_comb begin
        color_d = color_q;
        if (chord) begin
            color_d = INIT_VAL;
        end else if (step[0] && step[1]) begin
            color_d = color_q;
        end else if (step[0]) begin
            if (color_q != COLOR_MAX) begin
                color_d = color_q + COLOR_W'(1);
            end else if (WRAP != 0) begin
                color_d = '0;
            end
        end else if (step[1]) begin
            if (color_q != '0) begin
                color_d = color_q - COLOR_W'(1);
            end else if (WRAP != 0) begin
                color_d = COLOR_MAX;
            end
        end
        color_changed_d = (color_d != color_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q         <= INIT_VAL;
            color_changed_q <= 1'b0;
            dip_s1_q        <= '0;
            squares_q       <= '0;
        end else begin
            color_q         <= color_d;
            color_changed_q <= color_changed_d;
            dip_s1_q        <= dip_switch;
            squares_q       <= dip_s1_q;
        end
    end

    assign color         = color_q;
    assign squares       = squares_q;
    assign color_changed = color_changed_q;

endmodule
